// File: rtl/vga_pkg.sv
// Shared VGA definitions: nominal 800x600 raster constants, the sync bundle
// carried alongside pixel data, and a helper to size framebuffer addresses.
package vga_pkg;

    localparam int VGA_HSIZE = 800;
    localparam int VGA_VSIZE = 600;
    localparam int VGA_PIX_W = 8;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    // Address bits needed for a source frame replicated by 2^scale_log2.
    function automatic int fb_addr_w(input int hsize, input int vsize, input int scale_log2);
        return $clog2((hsize >> scale_log2) * (vsize >> scale_log2));
    endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port between the scanout stage and a synchronous-read RAM.
interface vga_fb_scanout_if #(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 8
);
    // fb_rd_en qualifies fb_addr for exactly one cycle. There is no ready: the
    // RAM accepts every strobe and presents fb_rdata a fixed RD_LAT cycles later.
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_rdata;

    modport master (output fb_rd_en, output fb_addr, input fb_rdata);
    modport slave  (input fb_rd_en, input fb_addr, output fb_rdata);

endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for the {hsync, vsync, de} bundle; each bit
// resets to its own inactive level so blanking is clean out of reset.
module vga_sync_delay #(
    parameter int         DEPTH   = 3,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: turns raster position into replicated framebuffer read
// addresses and realigns sync/de with the pixel returned RD_LAT cycles later.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int HSIZE      = VGA_HSIZE,
    parameter int VSIZE      = VGA_VSIZE,
    parameter int SCALE_LOG2 = 1,
    parameter int ADDR_W     = 19,
    parameter int PIX_W      = VGA_PIX_W,
    parameter int RD_LAT     = 2,
    parameter bit HSPP       = 1'b1,
    parameter bit VSPP       = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_hdata,
    input  logic [WIDTH-1:0]   in_vdata,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_de,
    vga_fb_scanout_if.master   fb,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de,
    output logic [PIX_W-1:0]   out_pixel
);

    localparam int                SRC_W    = HSIZE >> SCALE_LOG2;
    localparam logic [1:0]        REP_MAX  = 2'((1 << SCALE_LOG2) - 1);
    localparam logic [WIDTH-1:0]  H_LAST   = WIDTH'(HSIZE - 1);
    localparam logic [WIDTH-1:0]  V_LAST   = WIDTH'(VSIZE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    logic [ADDR_W-1:0] addr_cur, addr_cur_nxt;
    logic [ADDR_W-1:0] line_base, line_base_nxt;
    logic [1:0]        hrep, hrep_nxt;
    logic [1:0]        vrep, vrep_nxt;

    logic [ADDR_W-1:0] addr_eff, base_eff;
    logic [1:0]        hrep_eff, vrep_eff;
    logic              resync, line_end, frame_end;

    logic              rd_en_q;
    logic [ADDR_W-1:0] fb_addr_q;

    // A visible pixel at the raster origin restarts the walk from a clean state,
    // so all arithmetic below runs on the "effective" (possibly zeroed) counters.
    always_comb begin
        resync    = in_de && (in_hdata == '0) && (in_vdata == '0);
        line_end  = (in_hdata == H_LAST);
        frame_end = line_end && (in_vdata == V_LAST);

        addr_eff = resync ? '0 : addr_cur;
        base_eff = resync ? '0 : line_base;
        hrep_eff = resync ? '0 : hrep;
        vrep_eff = resync ? '0 : vrep;

        addr_cur_nxt  = addr_cur;
        line_base_nxt = line_base;
        hrep_nxt      = hrep;
        vrep_nxt      = vrep;

        if (in_de) begin
            if (frame_end) begin
                addr_cur_nxt  = '0;
                line_base_nxt = '0;
                hrep_nxt      = '0;
                vrep_nxt      = '0;
            end else if (line_end) begin
                hrep_nxt = '0;
                if (vrep_eff == REP_MAX) begin
                    vrep_nxt      = '0;
                    line_base_nxt = base_eff + ROW_STEP;
                    addr_cur_nxt  = base_eff + ROW_STEP;
                end else begin
                    // Replay the same source row for the next output line.
                    vrep_nxt      = vrep_eff + 2'd1;
                    line_base_nxt = base_eff;
                    addr_cur_nxt  = base_eff;
                end
            end else begin
                line_base_nxt = base_eff;
                vrep_nxt      = vrep_eff;
                if (hrep_eff == REP_MAX) begin
                    hrep_nxt     = '0;
                    addr_cur_nxt = addr_eff + 1'b1;
                end else begin
                    hrep_nxt     = hrep_eff + 2'd1;
                    addr_cur_nxt = addr_eff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_cur  <= '0;
            line_base <= '0;
            hrep      <= '0;
            vrep      <= '0;
            rd_en_q   <= 1'b0;
            fb_addr_q <= '0;
        end else begin
            addr_cur  <= addr_cur_nxt;
            line_base <= line_base_nxt;
            hrep      <= hrep_nxt;
            vrep      <= vrep_nxt;
            rd_en_q   <= in_de;
            if (in_de) begin
                fb_addr_q <= addr_eff;
            end
        end
    end

    assign fb.fb_rd_en = rd_en_q;
    assign fb.fb_addr  = fb_addr_q;

    // Sync bundle travels address register + RAM latency, then shares the
    // output register with the pixel so both leave on the same edge.
    sync_t sync_in, sync_dly;

    assign sync_in = '{hsync: in_hsync, vsync: in_vsync, de: in_de};

    vga_sync_delay #(
        .DEPTH   (RD_LAT + 1),
        .RST_VAL ({~HSPP, ~VSPP, 1'b0})
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_in),
        .q     (sync_dly)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_hsync <= ~HSPP;
            out_vsync <= ~VSPP;
            out_de    <= 1'b0;
            out_pixel <= '0;
        end else begin
            out_hsync <= sync_dly.hsync;
            out_vsync <= sync_dly.vsync;
            out_de    <= sync_dly.de;
            out_pixel <= sync_dly.de ? fb.fb_rdata : '0;
        end
    end

endmodule
